// File: rtl/gwa_pkg.sv
// Shared types and defaults for the payout sequencer: command codes, FSM states,
// and the one-hot mapping from a command to its actuator strobe.
package gwa_pkg;

  typedef enum logic [1:0] {
    CMD_C10 = 2'd0,
    CMD_C20 = 2'd1,
    CMD_EU1 = 2'd2,
    CMD_EU2 = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STROBE    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam int PULSE_LEN_DEF = 4;
  localparam int TIMEOUT_DEF   = 255;
  localparam int DEPTH_DEF     = 4;

  // Bit order matches {eu2, eu1, c20, c10}.
  function automatic logic [3:0] cmd_onehot(input cmd_t c);
    logic [3:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/gwa_cmd_fifo.sv
// Small synchronous command FIFO; a push into a full FIFO only lands when the
// same cycle also pops, so occupancy never exceeds DEPTH.
module gwa_cmd_fifo
  import gwa_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  cmd_t          din,
  output cmd_t          dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = pop && !empty;
  assign do_wr = push && (!full || do_rd);
  assign dout  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/gwa_payout_sequencer.sv
// Queues vending-FSM output pulses and replays them one at a time to slow
// actuators as fixed-width strobes, with done handshake, timeout and drop flags.
module gwa_payout_sequencer
  import gwa_pkg::*;
#(
  parameter int PULSE_LEN = PULSE_LEN_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_c10,
  input  logic          req_c20,
  input  logic          req_eu1,
  input  logic          req_eu2,
  input  logic          act_done,
  input  logic          clr_err,
  output logic          act_c10,
  output logic          act_c20,
  output logic          act_eu1,
  output logic          act_eu2,
  output logic          busy,
  output logic [CW-1:0] pending,
  output logic          drop,
  output logic          fault
);

  state_t        state;
  cmd_t          cmd_reg;
  cmd_t          din, dout;
  logic [3:0]    req, act_q;
  logic [7:0]    scnt;
  logic [15:0]   tcnt;
  logic          push, pop, push_ok, full, empty, multi;
  logic          drop_set, fault_set, busy_nxt;
  logic [CW-1:0] count_nxt;

  assign req   = {req_eu2, req_eu1, req_c20, req_c10};
  assign push  = |req;
  assign multi = (req & (req - 4'd1)) != 4'd0;

  always_comb begin
    din = CMD_EU2;
    if (req_c10)      din = CMD_C10;
    else if (req_c20) din = CMD_C20;
    else if (req_eu1) din = CMD_EU1;
  end

  assign pop       = (state == IDLE) && !empty;
  assign push_ok   = push && (!full || pop);
  assign drop_set  = multi || (push && full && !pop);
  assign fault_set = (state == WAIT_DONE) && !act_done && (tcnt == '0);

  // busy is registered, so it is built from the post-edge state and occupancy.
  assign count_nxt = pending + CW'(push_ok) - CW'(pop);
  assign busy_nxt  = pop || (state == STROBE) || (state == WAIT_DONE) ||
                     (count_nxt != '0);

  gwa_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .count (pending),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cmd_reg <= CMD_C10;
      act_q   <= '0;
      scnt    <= '0;
      tcnt    <= '0;
      drop    <= 1'b0;
      fault   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      drop  <= drop_set  | (drop  & ~clr_err);
      fault <= fault_set | (fault & ~clr_err);
      busy  <= busy_nxt;
      case (state)
        IDLE: begin
          act_q <= '0;
          if (pop) begin
            cmd_reg <= dout;
            act_q   <= cmd_onehot(dout);
            scnt    <= 8'(PULSE_LEN - 1);
            state   <= STROBE;
          end
        end
        STROBE: begin
          if (scnt == '0) begin
            act_q <= '0;
            tcnt  <= 16'(TIMEOUT - 1);
            state <= WAIT_DONE;
          end else begin
            act_q <= cmd_onehot(cmd_reg);
            scnt  <= scnt - 8'd1;
          end
        end
        WAIT_DONE: begin
          act_q <= '0;
          // On timeout the command is simply abandoned; fault_set records it.
          if (act_done || tcnt == '0) state <= GAP;
          else                        tcnt  <= tcnt - 16'd1;
        end
        GAP: begin
          act_q <= '0;
          state <= IDLE;
        end
        default: begin
          act_q <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign act_c10 = act_q[0];
  assign act_c20 = act_q[1];
  assign act_eu1 = act_q[2];
  assign act_eu2 = act_q[3];

endmodule

// File: tb/tb_gwa_payout_sequencer.sv
// Directed bench for gwa_payout_sequencer: stimulus pushes expected strobes into
// a scoreboard queue, a negedge monitor pops and compares each observed strobe.
module tb_gwa_payout_sequencer;

  localparam int C10 = 0, C20 = 1, EU1 = 2, EU2 = 3;

  typedef struct {
    int cmd;
    int start;
    int len;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_c10, req_c20, req_eu1, req_eu2;
  logic       act_done, clr_err;
  logic       act_c10, act_c20, act_eu1, act_eu2;
  logic       busy, drop, fault;
  logic [2:0] pending;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  logic       done_level = 1'b0;
  bit         auto_done = 1'b0;
  int         dcnt = 0;
  logic [3:0] act_prev = '0;

  gwa_payout_sequencer #(.PULSE_LEN(4), .TIMEOUT(10), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_c10(req_c10), .req_c20(req_c20), .req_eu1(req_eu1), .req_eu2(req_eu2),
    .act_done(act_done), .clr_err(clr_err),
    .act_c10(act_c10), .act_c20(act_c20), .act_eu1(act_eu1), .act_eu2(act_eu2),
    .busy(busy), .pending(pending), .drop(drop), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  function automatic logic [3:0] acts();
    return {act_eu2, act_eu1, act_c20, act_c10};
  endfunction

  // Actuator model: either a driven level, or a one-cycle done pulse 3 cycles
  // after each strobe falls.
  always @(negedge clk) begin
    if (auto_done) begin
      act_done = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) act_done = 1'b1;
      end
      if (act_prev != 4'd0 && acts() == 4'd0) dcnt = 3;
      act_prev = acts();
    end else begin
      act_done = done_level;
      act_prev = '0;
      dcnt     = 0;
    end
  end

  // Monitor / scoreboard.
  bit         in_s = 1'b0;
  logic [3:0] cur = '0;
  int         cur_start = 0, cur_len = 0;

  task automatic finish_strobe();
    exp_t e;
    logic [3:0] ev;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_strobe actual=%b required=none (start %0d)", cur, cur_start);
    end else begin
      e  = exp_q.pop_front();
      ev = '0;
      ev[e.cmd] = 1'b1;
      chk("strobe_cmd", int'(cur), int'(ev));
      if (e.start >= 0) chk("strobe_start", cur_start, e.start);
      chk("strobe_len", cur_len, e.len);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] v;
    v = acts();
    if (in_s && v != cur) begin
      finish_strobe();
      in_s = 1'b0;
    end
    if (in_s) cur_len++;
    else if (v != 4'd0) begin
      in_s      = 1'b1;
      cur       = v;
      cur_start = cyc;
      cur_len   = 1;
      chk("onehot", int'($onehot(v)), 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input logic [3:0] r);
    {req_eu2, req_eu1, req_c20, req_c10} = r;
  endtask

  task automatic expect_strobe(input int cmd, input int start, input int len);
    exp_t e;
    e.cmd = cmd; e.start = start; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (!busy && exp_q.size() == 0 && !in_s) break;
      tick(1);
    end
    chk({name, "_drained"}, int'(!busy && exp_q.size() == 0 && !in_s), 1);
  endtask

  initial begin
    int c0;
    rst = 1'b0; clr_err = 1'b0;
    set_req(4'b0000);
    tick(3);
    chk("rst_pending", int'(pending), 0);
    chk("rst_busy",    int'(busy), 0);
    chk("rst_drop",    int'(drop), 0);
    chk("rst_fault",   int'(fault), 0);
    chk("rst_act",     int'(acts()), 0);
    rst = 1'b1;
    tick(2);

    // Single request, done held high.
    done_level = 1'b1;
    tick(1);
    c0 = cyc;
    set_req(4'b0010);
    expect_strobe(C20, c0 + 2, 4);
    tick(1);
    set_req(4'b0000);
    chk("t1_pending", int'(pending), 1);
    chk("t1_busy_early", int'(busy), 1);
    tick(6);
    chk("t1_busy_gap", int'(busy), 1);
    tick(1);
    chk("t1_busy_idle", int'(busy), 0);
    chk("t1_drop", int'(drop), 0);
    chk("t1_fault", int'(fault), 0);
    drain("t1");

    // Queueing with delayed done pulses.
    auto_done = 1'b1;
    tick(2);
    c0 = cyc;
    set_req(4'b0100); expect_strobe(EU1, c0 + 2, 4);
    tick(1);
    set_req(4'b1000); expect_strobe(EU2, -1, 4);
    tick(1);
    set_req(4'b0001); expect_strobe(C10, -1, 4);
    tick(1);
    set_req(4'b0000);
    chk("t2_pending_peak", int'(pending), 2);
    drain("t2");
    chk("t2_drop", int'(drop), 0);
    chk("t2_fault", int'(fault), 0);

    // Overflow with done held low, then released.
    auto_done = 1'b0; done_level = 1'b0;
    tick(2);
    set_req(4'b0001); expect_strobe(C10, -1, 4); tick(1);
    set_req(4'b0010); expect_strobe(C20, -1, 4); tick(1);
    set_req(4'b0100); expect_strobe(EU1, -1, 4); tick(1);
    set_req(4'b1000); expect_strobe(EU2, -1, 4); tick(1);
    set_req(4'b0001); expect_strobe(C10, -1, 4); tick(1);
    set_req(4'b0010); tick(1);
    set_req(4'b0000);
    chk("t3_pending_full", int'(pending), 4);
    chk("t3_drop", int'(drop), 1);
    done_level = 1'b1;
    drain("t3");
    chk("t3_fault", int'(fault), 0);
    chk("t3_drop_sticky", int'(drop), 1);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    chk("t3_drop_clr", int'(drop), 0);

    // Timeout; clr_err coinciding with the fault edge must lose.
    done_level = 1'b0;
    tick(2);
    c0 = cyc;
    set_req(4'b1000); expect_strobe(EU2, c0 + 2, 4); tick(1);
    set_req(4'b0100); expect_strobe(EU1, c0 + 18, 4); tick(1);
    set_req(4'b0000);
    while (cyc < c0 + 15) tick(1);
    chk("t4_fault_before", int'(fault), 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("t4_fault_set_wins", int'(fault), 1);
    done_level = 1'b1;
    drain("t4");
    chk("t4_drop", int'(drop), 0);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    chk("t4_fault_clr", int'(fault), 0);

    // Collision, then reset in the middle of the strobe with a command queued.
    tick(2);
    c0 = cyc;
    set_req(4'b1001); expect_strobe(C10, c0 + 2, 2); tick(1);
    set_req(4'b0100);
    chk("t5_drop", int'(drop), 1);
    tick(1);
    set_req(4'b0000);
    chk("t5_pending_queued", int'(pending), 1);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("t5_rst_act", int'(acts()), 0);
    chk("t5_rst_pending", int'(pending), 0);
    chk("t5_rst_drop", int'(drop), 0);
    chk("t5_rst_busy", int'(busy), 0);
    tick(1);
    rst = 1'b1;
    tick(20);
    chk("t5_no_strobe", int'(exp_q.size() == 0 && !in_s && acts() == 4'd0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gwa_payout_sequencer.md
Name: gwa_payout_sequencer

Overview:
Sequences the physical output actuators of the drink vending machine: the two drink dispensers (10/20) and the two coin-return chutes (1/2 euro). It accepts the single-cycle output pulses of the vending FSM and queues them in a small command FIFO. It replays them one at a time to slow actuators as fixed-width strobes, waits for an actuator-done handshake, and flags timeouts and dropped commands. It sits between the vending FSM outputs and the actuator driver pins.

Parameters:
PULSE_LEN, 4, actuator strobe width in clk cycles (legal range 1..255)
TIMEOUT, 255, max cycles in WAIT_DONE before fault (legal range 1..65535)
DEPTH, 4, command FIFO entries (power of two, legal range 2..16)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
req_c10  in  1  single-cycle request: dispense drink 10
req_c20  in  1  single-cycle request: dispense drink 20
req_eu1  in  1  single-cycle request: return 1-euro coin
req_eu2  in  1  single-cycle request: return 2-euro coin
act_done  in  1  actuator finished (level or pulse), sampled only in WAIT_DONE
clr_err  in  1  clears sticky drop/fault flags
act_c10  out  1  dispenser-10 strobe
act_c20  out  1  dispenser-20 strobe
act_eu1  out  1  1-euro return strobe
act_eu2  out  1  2-euro return strobe
busy  out  1  high when state != IDLE or FIFO non-empty
pending  out  $clog2(DEPTH+1)  FIFO occupancy
drop  out  1  sticky: a request was lost
fault  out  1  sticky: actuator timeout

Behaviour:
- Reset (rst==0 at a rising edge): all outputs 0, pending=0, FIFO cleared, state IDLE, counters 0. This applies mid-strobe: the strobe drops at that edge and the in-flight command is discarded.
- Enqueue:
  - Any req_* high is pushed at that edge.
  - If more than one req_* is high in the same cycle, only the highest-priority one is pushed (c10 > c20 > eu1 > eu2) and drop is set.
- Full FIFO:
  - Push with no pop in the same cycle: the request is discarded and drop is set.
  - Push and pop in the same cycle: both succeed and pending is unchanged.
- State machine states: IDLE, STROBE, WAIT_DONE, GAP.
  - IDLE: if pending!=0, pop the head into cmd_reg and go to STROBE; otherwise stay.
  - STROBE: assert exactly one act_* matching cmd_reg for PULSE_LEN consecutive cycles, then go to WAIT_DONE. act_done is ignored in this state.
  - WAIT_DONE: all act_* low.
    - act_done==1: go to GAP.
    - TIMEOUT cycles elapse without act_done: set fault, discard the command, go to GAP.
  - GAP: exactly one cycle with all act_* low, then IDLE.
- Latency: a request in cycle 0 with the block idle and empty gives pending=1 in cycle 1 and act_* high in cycles 2..PULSE_LEN+1.
  - Back-to-back commands are separated by at least 1 (WAIT_DONE, if act_done is already high) + 1 (GAP) + 1 (IDLE) low cycles.
- At most one act_* is high in any cycle. All act_* are registered outputs.
- Counters: the strobe counter is 8 bits and the timeout counter is 16 bits. Both reload on state entry and never wrap.
- Sticky flags:
  - drop and fault are set by their events and cleared by clr_err.
  - If a set event and clr_err occur in the same cycle, set wins.
- pending and busy are registered and reflect state after the edge.

Decomposition:
- Package gwa_pkg holds:
  - cmd_t, a 2-bit enum: CMD_C10=0, CMD_C20=1, CMD_EU1=2, CMD_EU2=3.
  - state_t, the enum for IDLE/STROBE/WAIT_DONE/GAP.
  - Default parameter constants.
- Sub-module gwa_cmd_fifo: synchronous FIFO of cmd_t with DEPTH entries.
  - Ports: push, pop, din, dout, count, full, empty.
  - Same clk/rst convention as the parent.
  - Handles pointer wrap and simultaneous push/pop.
- The priority encoder, FSM and counters stay in the top level.

Test Plan:
- Single request: req_c20 pulse in cycle 0, act_done held high -> act_c20 high in cycles 2..5 only (PULSE_LEN=4), busy drops after GAP, drop=fault=0.
- Queueing: pulses req_eu1, req_eu2, req_c10 on consecutive cycles, act_done pulsed 3 cycles after each strobe ends -> strobes appear in order eu1, eu2, c10, never overlapping; pending peaks at 2.
- Overflow, DEPTH=4, act_done held 0:
  - Six requests in 6 cycles -> one in flight, 4 queued, sixth discarded, drop=1.
  - Released later -> exactly 5 strobes.
- Timeout, TIMEOUT=10, act_done held 0:
  - One request -> fault=1 exactly 10 cycles after WAIT_DONE entry, the next queued command still executes.
  - clr_err -> fault=0.
- Collision and reset: req_c10 and req_eu2 high together -> only act_c10 strobes, drop=1. Then rst=0 during STROBE -> act_c10=0, pending=0, drop=0 at that edge, and no strobe after rst is released.
